// File: rtl/async_mem_wb_arbiter.sv
// async_mem_wb_arbiter: round-robin arbiter that lets NM Wishbone masters share
// one async-memory slave port. Each grant covers exactly one transfer. A
// one-cycle release gap follows every transfer. A per-transfer watchdog turns a
// hung access into an error pulse, then drains the slave for DRAIN cycles.
module async_mem_wb_arbiter #(
   parameter int NM    = 2,
   parameter int TO_W  = 8,
   parameter int DRAIN = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n_i,
   input  logic [NM-1:0]     m_cyc_i,
   input  logic [NM-1:0]     m_stb_i,
   input  logic [NM-1:0]     m_we_i,
   input  logic [NM*32-1:0]  m_adr_i,
   input  logic [NM*32-1:0]  m_dat_i,
   input  logic [NM*4-1:0]   m_sel_i,
   output logic [31:0]       m_dat_o,
   output logic [NM-1:0]     m_ack_o,
   output logic [NM-1:0]     m_err_o,
   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic              s_we_o,
   output logic [31:0]       s_adr_o,
   output logic [31:0]       s_dat_o,
   output logic [3:0]        s_sel_o,
   input  logic [31:0]       s_dat_i,
   input  logic              s_ack_i,
   input  logic [TO_W-1:0]   timeout_i,
   output logic [NM-1:0]     gnt_o,
   output logic              busy_o
);

   localparam int IW = (NM > 1) ? $clog2(NM) : 1;
   // The drain counter only has to hold DRAIN-1.
   localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      GAP     = 2'd2,
      HOLDOFF = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [NM-1:0]     gnt_q, gnt_d;
   logic [IW-1:0]     last_q, last_d;
   logic [TO_W-1:0]   wdog_q, wdog_d;
   logic [DW-1:0]     drain_q, drain_d;
   logic              busy_q, busy_d;

   logic [31:0]       adr_hold_q, adr_hold_d;
   logic [31:0]       dat_hold_q, dat_hold_d;
   logic [3:0]        sel_hold_q, sel_hold_d;
   logic              we_hold_q, we_hold_d;

   logic [NM-1:0]     req;
   logic [31:0]       adr_a [NM];
   logic [31:0]       dat_a [NM];
   logic [3:0]        sel_a [NM];
   logic              win_found;
   logic [IW-1:0]     win_idx;
   logic              bus_on;
   logic [NM-1:0]     ack_c, err_c;
   logic              cur_cyc, cur_stb, cur_we;
   logic [31:0]       cur_adr, cur_dat;
   logic [3:0]        cur_sel;

   assign req = m_cyc_i & m_stb_i;

   // Unpack the flat master buses so the granted master can be picked by index.
   always_comb begin
      for (int k = 0; k < NM; k++) begin
         adr_a[k] = m_adr_i[32*k +: 32];
         dat_a[k] = m_dat_i[32*k +: 32];
         sel_a[k] = m_sel_i[4*k +: 4];
      end
   end

   // last_q always names the most recently granted master, so it doubles as the mux select.
   assign cur_cyc = m_cyc_i[last_q];
   assign cur_stb = m_stb_i[last_q];
   assign cur_we  = m_we_i[last_q];
   assign cur_adr = adr_a[last_q];
   assign cur_dat = dat_a[last_q];
   assign cur_sel = sel_a[last_q];

   // Round-robin search starting just after the last winner.
   always_comb begin
      int j;
      win_found = 1'b0;
      win_idx   = '0;
      j         = 0;
      for (int i = 1; i <= NM; i++) begin
         j = int'(last_q) + i;
         if (j >= NM) j = j - NM;
         if (!win_found && req[IW'(j)]) begin
            win_found = 1'b1;
            win_idx   = IW'(j);
         end
      end
   end

   // Next-state logic plus the combinational ack/err routing of the current state.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      wdog_d  = wdog_q;
      drain_d = drain_q;
      ack_c   = '0;
      err_c   = '0;
      bus_on  = 1'b0;
      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (win_found) begin
               gnt_d[win_idx] = 1'b1;
               last_d         = win_idx;
               wdog_d         = timeout_i;
               state_d        = BUSY;
            end
         end
         BUSY: begin
            bus_on = 1'b1;
            // A zero load never reaches 1, which is how a zero limit disables the watchdog.
            if (wdog_q != '0) wdog_d = wdog_q - TO_W'(1);
            if (s_ack_i) begin
               ack_c   = gnt_q;
               state_d = GAP;
            end else if (!cur_cyc) begin
               gnt_d   = '0;
               state_d = IDLE;
            end else if (wdog_q == TO_W'(1)) begin
               err_c   = gnt_q;
               drain_d = DW'(DRAIN - 1);
               state_d = HOLDOFF;
            end
         end
         GAP: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
         HOLDOFF: begin
            // Late slave acks are simply not routed anywhere while draining.
            if (drain_q == '0) begin
               gnt_d   = '0;
               state_d = IDLE;
            end else begin
               drain_d = drain_q - DW'(1);
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // Slave-side data lines follow the granted master during BUSY and hold otherwise.
   always_comb begin
      adr_hold_d = bus_on ? cur_adr : adr_hold_q;
      dat_hold_d = bus_on ? cur_dat : dat_hold_q;
      sel_hold_d = bus_on ? cur_sel : sel_hold_q;
      we_hold_d  = bus_on ? cur_we  : we_hold_q;
   end

   // Arbiter FSM and its registered outputs.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         last_q  <= IW'(NM - 1);
         wdog_q  <= '0;
         drain_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
         drain_q <= drain_d;
         busy_q  <= busy_d;
      end
   end

   // Held copy of the last granted master's request fields (datapath, no reset).
   always_ff @(posedge wb_clk_i) begin
      adr_hold_q <= adr_hold_d;
      dat_hold_q <= dat_hold_d;
      sel_hold_q <= sel_hold_d;
      we_hold_q  <= we_hold_d;
   end

   assign s_cyc_o = bus_on & cur_cyc;
   assign s_stb_o = bus_on & cur_stb;
   assign s_adr_o = adr_hold_d;
   assign s_dat_o = dat_hold_d;
   assign s_sel_o = sel_hold_d;
   assign s_we_o  = we_hold_d;
   assign m_dat_o = s_dat_i;
   assign m_ack_o = ack_c;
   assign m_err_o = err_c;
   assign gnt_o   = gnt_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_async_mem_wb_arbiter.sv
// Testbench for async_mem_wb_arbiter (NM=4): table-driven single transfers,
// round-robin sequences, watchdog abort/holdoff, ack-vs-expiry, master abort
// and asynchronous reset, with a scoreboard of expected slave transfers.
module tb_async_mem_wb_arbiter;

   localparam int NM    = 4;
   localparam int TO_W  = 8;
   localparam int DRAIN = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
   logic [NM*32-1:0]  m_adr_i, m_dat_i;
   logic [NM*4-1:0]   m_sel_i;
   logic [31:0]       m_dat_o;
   logic [NM-1:0]     m_ack_o, m_err_o;
   logic              s_cyc_o, s_stb_o, s_we_o;
   logic [31:0]       s_adr_o, s_dat_o;
   logic [3:0]        s_sel_o;
   logic [31:0]       s_dat_i;
   logic              s_ack_i;
   logic [TO_W-1:0]   timeout_i;
   logic [NM-1:0]     gnt_o;
   logic              busy_o;

   always #5 clk = ~clk;

   async_mem_wb_arbiter #(.NM(NM), .TO_W(TO_W), .DRAIN(DRAIN)) dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .m_cyc_i    (m_cyc_i),
      .m_stb_i    (m_stb_i),
      .m_we_i     (m_we_i),
      .m_adr_i    (m_adr_i),
      .m_dat_i    (m_dat_i),
      .m_sel_i    (m_sel_i),
      .m_dat_o    (m_dat_o),
      .m_ack_o    (m_ack_o),
      .m_err_o    (m_err_o),
      .s_cyc_o    (s_cyc_o),
      .s_stb_o    (s_stb_o),
      .s_we_o     (s_we_o),
      .s_adr_o    (s_adr_o),
      .s_dat_o    (s_dat_o),
      .s_sel_o    (s_sel_o),
      .s_dat_i    (s_dat_i),
      .s_ack_i    (s_ack_i),
      .timeout_i  (timeout_i),
      .gnt_o      (gnt_o),
      .busy_o     (busy_o)
   );

   typedef struct {
      int          m;
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          dly;
      logic [31:0] rdat;
   } vec_t;

   typedef struct {
      int          m;
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [31:0] rdat;
   } exp_t;

   exp_t sbq[$];
   vec_t vt[5];
   int   tests = 0;
   int   fails = 0;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] madr(input int k);
      return 32'h4000_0000 + 32'(k) * 32'h10;
   endfunction

   function automatic logic [31:0] mdat(input int k);
      return 32'h0D00_0000 + 32'(k);
   endfunction

   task automatic set_master(input int k, input logic on, input logic we,
                             input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel);
      m_cyc_i[k]          = on;
      m_stb_i[k]          = on;
      m_we_i[k]           = we;
      m_adr_i[32*k +: 32] = adr;
      m_dat_i[32*k +: 32] = dat;
      m_sel_i[4*k +: 4]   = sel;
   endtask

   task automatic push_exp(input int k, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input logic [31:0] rdat);
      exp_t e;
      e.m = k; e.we = we; e.adr = adr; e.dat = dat; e.sel = sel; e.rdat = rdat;
      sbq.push_back(e);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_o && n < 100) begin
         cyc();
         n++;
      end
      chk("idle_reached", 32'(busy_o), 32'd0);
   endtask

   task automatic wait_stb(output bit ok);
      int n = 0;
      while (!s_stb_o && n < 50) begin
         cyc();
         n++;
      end
      ok = s_stb_o;
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL stb_timeout: s_stb_o=%0b after %0d cycles, required 1", s_stb_o, n);
      end
   endtask

   // Called in the cycle where s_ack_i is high: pops the expected transfer.
   task automatic check_ack();
      exp_t e;
      if (sbq.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL sb_empty: ack seen with m_ack_o=%b, required no pending transfer", m_ack_o);
      end else begin
         e = sbq.pop_front();
         chk("ack",        32'(m_ack_o), 32'(1) << e.m);
         chk("err_at_ack", 32'(m_err_o), 32'd0);
         chk("s_adr",      s_adr_o, e.adr);
         chk("s_dat",      s_dat_o, e.dat);
         chk("s_sel",      32'(s_sel_o), 32'(e.sel));
         chk("s_we",       32'(s_we_o), 32'(e.we));
         chk("m_dat",      m_dat_o, e.rdat);
      end
   endtask

   task automatic run_xfer(input vec_t v);
      wait_idle();
      set_master(v.m, 1'b1, v.we, v.adr, v.dat, v.sel);
      push_exp(v.m, v.we, v.adr, v.dat, v.sel, v.rdat);
      cyc();
      chk("stb_latency", 32'(s_stb_o), 32'd1);
      chk("gnt",         32'(gnt_o), 32'(1) << v.m);
      for (int i = 0; i < v.dly; i++) begin
         chk("no_early_ack", 32'(m_ack_o), 32'd0);
         cyc();
      end
      s_ack_i = 1'b1;
      s_dat_i = v.rdat;
      #1;
      check_ack();
      cyc();
      s_ack_i = 1'b0;
      set_master(v.m, 1'b0, v.we, v.adr, v.dat, v.sel);
      #1;
      chk("gap_stb",  32'(s_stb_o), 32'd0);
      chk("gap_gnt",  32'(gnt_o), 32'(1) << v.m);
      chk("gap_busy", 32'(busy_o), 32'd1);
      chk("hold_adr", s_adr_o, v.adr);
   endtask

   task automatic rr_seq(input logic [3:0] mask, input int o0, input int o1,
                         input int o2, input int o3, input int n, input bit drop_each);
      int ord[4];
      bit ok;
      ord[0] = o0; ord[1] = o1; ord[2] = o2; ord[3] = o3;
      wait_idle();
      for (int k = 0; k < NM; k++)
         if (mask[k]) set_master(k, 1'b1, (k % 2) == 1, madr(k), mdat(k), 4'hF);
      for (int i = 0; i < n; i++)
         push_exp(ord[i], (ord[i] % 2) == 1, madr(ord[i]), mdat(ord[i]), 4'hF,
                  32'h5000_0000 + 32'(i));
      for (int i = 0; i < n; i++) begin
         wait_stb(ok);
         if (!ok) return;
         chk("rr_gnt", 32'(gnt_o), 32'(1) << ord[i]);
         s_ack_i = 1'b1;
         s_dat_i = 32'h5000_0000 + 32'(i);
         #1;
         check_ack();
         cyc();
         s_ack_i = 1'b0;
         if (drop_each) set_master(ord[i], 1'b0, 1'b0, madr(ord[i]), mdat(ord[i]), 4'hF);
         #1;
         chk("rr_gap_stb", 32'(s_stb_o), 32'd0);
      end
      for (int k = 0; k < NM; k++)
         if (mask[k]) set_master(k, 1'b0, 1'b0, madr(k), mdat(k), 4'hF);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
      $fatal(1, "global timeout");
   end

   initial begin
      int n;
      vt[0] = '{0, 1'b0, 32'h1000_0000, 32'h0000_0000, 4'hF, 3, 32'hA5A5_1234};
      vt[1] = '{1, 1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 4'h3, 0, 32'h0000_0000};
      vt[2] = '{2, 1'b0, 32'h3000_0008, 32'h0000_0000, 4'hC, 1, 32'h0BAD_F00D};
      vt[3] = '{3, 1'b1, 32'h4000_000C, 32'h1357_9BDF, 4'h1, 2, 32'h0000_0000};
      vt[4] = '{1, 1'b0, 32'h5000_0010, 32'h0000_0000, 4'h8, 0, 32'hCAFE_0001};

      rst_n     = 1'b0;
      m_cyc_i   = '0;
      m_stb_i   = '0;
      m_we_i    = '0;
      m_adr_i   = '0;
      m_dat_i   = '0;
      m_sel_i   = '0;
      s_ack_i   = 1'b0;
      s_dat_i   = 32'h1234_5678;
      timeout_i = '0;
      #1;
      chk("rst_gnt",   32'(gnt_o), 32'd0);
      chk("rst_busy",  32'(busy_o), 32'd0);
      chk("rst_ack",   32'(m_ack_o), 32'd0);
      chk("rst_err",   32'(m_err_o), 32'd0);
      chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
      chk("rst_s_stb", 32'(s_stb_o), 32'd0);
      chk("m_dat_pass", m_dat_o, 32'h1234_5678);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      cyc();

      // Single transfers from the table; the last one leaves last=1.
      for (int i = 0; i < 5; i++) run_xfer(vt[i]);

      // Masters 1 and 3 with last=1: 3 first, then 1.
      rr_seq(4'b1010, 3, 1, 0, 0, 2, 1'b1);

      // Masters 0 and 1 continuously (last=1): 0,1,0,1.
      rr_seq(4'b0011, 0, 1, 0, 1, 4, 1'b0);

      // Watchdog: timeout 5, no ack from the slave.
      wait_idle();
      timeout_i = 8'd5;
      set_master(2, 1'b1, 1'b0, madr(2), mdat(2), 4'hF);
      cyc();
      chk("wd_stb", 32'(s_stb_o), 32'd1);
      for (int b = 1; b <= 5; b++) begin
         chk("wd_no_ack", 32'(m_ack_o), 32'd0);
         if (b < 5) begin
            chk("wd_no_err", 32'(m_err_o), 32'd0);
            cyc();
         end else begin
            chk("wd_err", 32'(m_err_o), 32'b0100);
         end
      end
      cyc();
      set_master(2, 1'b0, 1'b0, madr(2), mdat(2), 4'hF);
      #1;
      chk("ho_err_one_cycle", 32'(m_err_o), 32'd0);
      chk("ho_gnt_held", 32'(gnt_o), 32'b0100);
      n = 0;
      while (busy_o && n < 40) begin
         chk("ho_stb", 32'(s_stb_o), 32'd0);
         if (n == 3) begin
            s_ack_i = 1'b1;
            #1;
            chk("ho_late_ack", 32'(m_ack_o), 32'd0);
         end
         cyc();
         s_ack_i = 1'b0;
         n++;
      end
      chk("ho_len", 32'(n), 32'(DRAIN));
      chk("ho_gnt_cleared", 32'(gnt_o), 32'd0);

      // Ack on the very cycle the watchdog would expire.
      wait_idle();
      timeout_i = 8'd3;
      set_master(3, 1'b1, 1'b1, madr(3), mdat(3), 4'h6);
      push_exp(3, 1'b1, madr(3), mdat(3), 4'h6, 32'h7777_0003);
      cyc();
      chk("coll_stb", 32'(s_stb_o), 32'd1);
      cyc();
      cyc();
      s_ack_i = 1'b1;
      s_dat_i = 32'h7777_0003;
      #1;
      check_ack();
      cyc();
      s_ack_i = 1'b0;
      set_master(3, 1'b0, 1'b0, madr(3), mdat(3), 4'h6);
      #1;
      chk("coll_gap_busy", 32'(busy_o), 32'd1);
      chk("coll_gap_stb",  32'(s_stb_o), 32'd0);
      cyc();
      chk("coll_to_idle", 32'(busy_o), 32'd0);

      // Master abort: cyc dropped mid-BUSY.
      timeout_i = 8'd0;
      wait_idle();
      set_master(0, 1'b1, 1'b0, madr(0), mdat(0), 4'hF);
      cyc();
      chk("abort_stb", 32'(s_stb_o), 32'd1);
      cyc();
      set_master(0, 1'b0, 1'b0, madr(0), mdat(0), 4'hF);
      #1;
      chk("abort_s_cyc", 32'(s_cyc_o), 32'd0);
      chk("abort_ack",   32'(m_ack_o), 32'd0);
      chk("abort_err",   32'(m_err_o), 32'd0);
      cyc();
      chk("abort_idle", 32'(busy_o), 32'd0);
      chk("abort_gnt",  32'(gnt_o), 32'd0);

      // Asynchronous reset in the middle of a master-1 transfer.
      wait_idle();
      set_master(1, 1'b1, 1'b0, madr(1), mdat(1), 4'hF);
      cyc();
      chk("pre_rst_gnt", 32'(gnt_o), 32'b0010);
      #1;
      rst_n   = 1'b0;
      s_ack_i = 1'b1;
      #1;
      chk("arst_gnt",   32'(gnt_o), 32'd0);
      chk("arst_busy",  32'(busy_o), 32'd0);
      chk("arst_ack",   32'(m_ack_o), 32'd0);
      chk("arst_err",   32'(m_err_o), 32'd0);
      chk("arst_s_cyc", 32'(s_cyc_o), 32'd0);
      chk("arst_s_stb", 32'(s_stb_o), 32'd0);
      s_ack_i = 1'b0;
      set_master(1, 1'b0, 1'b0, madr(1), mdat(1), 4'hF);
      set_master(0, 1'b1, 1'b0, madr(0), mdat(0), 4'hF);
      set_master(2, 1'b1, 1'b0, madr(2), mdat(2), 4'hF);
      push_exp(0, 1'b0, madr(0), mdat(0), 4'hF, 32'h9999_0000);
      #1;
      rst_n = 1'b1;
      cyc();
      chk("post_rst_gnt", 32'(gnt_o), 32'b0001);
      s_ack_i = 1'b1;
      s_dat_i = 32'h9999_0000;
      #1;
      check_ack();
      cyc();
      s_ack_i = 1'b0;
      set_master(0, 1'b0, 1'b0, madr(0), mdat(0), 4'hF);
      set_master(2, 1'b0, 1'b0, madr(2), mdat(2), 4'hF);
      wait_idle();

      chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
